lsu_mem_stage: RTL and testbench

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_mem_stage_if.sv | 32 +++
 rtl/lsu_mem_stage.sv | 126 ++++++++++++
 tb/tb_lsu_mem_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// Execute-stage request/response and word-bus signals of the load/store memory stage.
// slave = the LSU's view, master = the surrounding pipeline/memory.
interface lsu_mem_stage_if #(parameter int WIDTH = 32);
   logic             lsu_start;
   logic             lsu_we;
   logic [2:0]       lsu_funct3;
   logic [WIDTH-1:0] lsu_addr;
   logic [WIDTH-1:0] lsu_wdata;
   logic             lsu_busy;
   logic             lsu_done;
   logic             lsu_err;
   logic [WIDTH-1:0] lsu_rdata;
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH/8-1:0] mem_be;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_ack;
   logic [WIDTH-1:0] mem_rdata;

   modport slave (
      input  lsu_start, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_ack, mem_rdata,
      output lsu_busy, lsu_done, lsu_err, lsu_rdata,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output lsu_start, lsu_we, lsu_funct3, lsu_addr, lsu_wdata, mem_ack, mem_rdata,
      input  lsu_busy, lsu_done, lsu_err, lsu_rdata,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I load/store memory stage: one access at a time over a word bus with byte enables.
// Optional bus-wait timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   lsu_mem_stage_if.slave   bus
);
   if (WIDTH != 32) begin : g_width_chk
      $error("lsu_mem_stage: only WIDTH=32 is supported");
   end
   if (TIMEOUT < 1) begin : g_timeout_chk
      $error("lsu_mem_stage: TIMEOUT must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t state, state_nxt;

   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic        err_q;
   logic        bad;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt, ld_val, shifted;
   logic        to_hit;

   // Decode of the incoming request, used only while IDLE
   always_comb begin
      bad = bus.lsu_we ? (bus.lsu_funct3 > 3'd2)
                       : (bus.lsu_funct3 == 3'd3 || bus.lsu_funct3 > 3'd5);
      if (bus.lsu_funct3[1:0] == 2'b01 && bus.lsu_addr[0])          bad = 1'b1;
      if (bus.lsu_funct3[1:0] == 2'b10 && bus.lsu_addr[1:0] != 2'b00) bad = 1'b1;
      be_nxt    = 4'b0000;
      wdata_nxt = bus.lsu_wdata;
      case (bus.lsu_funct3[1:0])
         2'b00: begin
            be_nxt    = 4'b0001 << bus.lsu_addr[1:0];
            wdata_nxt = {4{bus.lsu_wdata[7:0]}};
         end
         2'b01: begin
            be_nxt    = bus.lsu_addr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{bus.lsu_wdata[15:0]}};
         end
         2'b10:   be_nxt = 4'b1111;
         default: be_nxt = 4'b0000;
      endcase
   end

   // Load lane select and extension
   always_comb begin
      shifted = bus.mem_rdata >> {lane_q, 3'b000};
      case (f3_q)
         3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ld_val = {24'h0, shifted[7:0]};
         3'b101:  ld_val = {16'h0, shifted[15:0]};
         default: ld_val = shifted;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   logic [15:0] to_cnt;
   always_ff @(posedge clk) begin
      if (rst || state != REQ) to_cnt <= '0;
      else if (!bus.mem_ack)   to_cnt <= to_cnt + 16'd1;
   end
   assign to_hit = (state == REQ) && !bus.mem_ack && (to_cnt == 16'(TIMEOUT - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.lsu_start) state_nxt = bad ? DONE : REQ;
         REQ:     if (bus.mem_ack || to_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         lane_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= 4'b0000;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (state == IDLE && bus.lsu_start) begin
            we_q    <= bus.lsu_we;
            f3_q    <= bus.lsu_funct3;
            lane_q  <= bus.lsu_addr[1:0];
            addr_q  <= {bus.lsu_addr[31:2], 2'b00};
            wdata_q <= wdata_nxt;
            be_q    <= be_nxt;
            err_q   <= bad;
         end
         if (state == REQ && bus.mem_ack && !we_q) rdata_q <= ld_val;
         if (to_hit) err_q <= 1'b1;
      end
   end

   assign bus.lsu_busy  = (state != IDLE);
   assign bus.lsu_done  = (state == DONE);
   assign bus.lsu_err   = err_q;
   assign bus.lsu_rdata = rdata_q;
   assign bus.mem_req   = (state == REQ);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_be    = be_q;
   assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: aligned/misaligned loads and stores, wait states,
// reset mid-access and the bus-wait behaviour with or without LSU_TIMEOUT_EN.
module tb_lsu_mem_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   lsu_mem_stage_if #(.WIDTH(32)) bus ();

   lsu_mem_stage #(.WIDTH(32), .TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request; checks bus hold during waits, completion cycle, result, and
   // that a start issued while done is high is dropped.
   task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int waits,
                         input logic [31:0] rd, input logic bad, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd);
      bus.lsu_start = 1'b1; bus.lsu_we = we; bus.lsu_funct3 = f3;
      bus.lsu_addr = a; bus.lsu_wdata = wd;
      tick();
      bus.lsu_start = 1'b0;
      if (!bad) begin
         for (int i = 0; i <= waits; i++) begin
            chk({tag, " req"},  32'(bus.mem_req), 32'd1);
            chk({tag, " busy"}, 32'(bus.lsu_busy), 32'd1);
            chk({tag, " addr"}, bus.mem_addr, a & 32'hFFFF_FFFC);
            chk({tag, " be"},   32'(bus.mem_be), 32'(exp_be));
            chk({tag, " we"},   32'(bus.mem_we), 32'(we));
            if (we) chk({tag, " wdata"}, bus.mem_wdata, exp_wd);
            chk({tag, " no done"}, 32'(bus.lsu_done), 32'd0);
            if (i == waits) begin
               bus.mem_ack = 1'b1; bus.mem_rdata = rd;
            end
            tick();
            bus.mem_ack = 1'b0; bus.mem_rdata = 32'h5A5A_5A5A;
         end
      end else begin
         chk({tag, " no req"}, 32'(bus.mem_req), 32'd0);
      end
      chk({tag, " done"},  32'(bus.lsu_done), 32'd1);
      chk({tag, " err"},   32'(bus.lsu_err), 32'(bad));
      chk({tag, " rdata"}, bus.lsu_rdata, exp_rd);
      chk({tag, " req off"}, 32'(bus.mem_req), 32'd0);
      bus.lsu_start = 1'b1;
      tick();
      bus.lsu_start = 1'b0;
      chk({tag, " idle"},    32'(bus.lsu_busy), 32'd0);
      chk({tag, " done 1c"}, 32'(bus.lsu_done), 32'd0);
   endtask

   initial begin
      int cnt;
      bus.lsu_start = 1'b0; bus.lsu_we = 1'b0; bus.lsu_funct3 = 3'b000;
      bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

      tick(); tick();
      chk("rst busy",  32'(bus.lsu_busy), 32'd0);
      chk("rst done",  32'(bus.lsu_done), 32'd0);
      chk("rst err",   32'(bus.lsu_err), 32'd0);
      chk("rst rdata", bus.lsu_rdata, 32'd0);
      chk("rst req",   32'(bus.mem_req), 32'd0);
      chk("rst we",    32'(bus.mem_we), 32'd0);
      chk("rst be",    32'(bus.mem_be), 32'd0);
      chk("rst addr",  bus.mem_addr, 32'd0);
      chk("rst wdata", bus.mem_wdata, 32'd0);
      rst = 1'b0;
      tick();

      //      tag     we  f3      addr          wdata         w  rdata          bad be       wdata exp     rdata exp
      run_op("lb",    0, 3'b000, 32'h0000_1003, 32'h0,        0, 32'h8012_3456, 0, 4'b1000, 32'h0,        32'hFFFF_FF80);
      run_op("sh",    1, 3'b001, 32'h0000_2002, 32'h0000_BEEF,3, 32'h1111_1111, 0, 4'b1100, 32'hBEEF_BEEF,32'hFFFF_FF80);
      run_op("lw mis",0, 3'b010, 32'h0000_3001, 32'h0,        0, 32'h0,         1, 4'b0000, 32'h0,        32'hFFFF_FF80);
      run_op("lbu",   0, 3'b100, 32'h0000_1001, 32'h0,        0, 32'h0000_F600, 0, 4'b0010, 32'h0,        32'h0000_00F6);
      run_op("lh",    0, 3'b001, 32'h0000_0002, 32'h0,        0, 32'h9ABC_0000, 0, 4'b1100, 32'h0,        32'hFFFF_9ABC);
      run_op("lhu",   0, 3'b101, 32'h0000_0000, 32'h0,        1, 32'h1111_8001, 0, 4'b0011, 32'h0,        32'h0000_8001);
      run_op("lw",    0, 3'b010, 32'h0000_4000, 32'h0,        2, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
      run_op("sb",    1, 3'b000, 32'h0000_5001, 32'h1234_56A5,0, 32'h2222_2222, 0, 4'b0010, 32'hA5A5_A5A5,32'hDEAD_BEEF);
      run_op("sw",    1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D,1, 32'h3333_3333, 0, 4'b1111, 32'hCAFE_F00D,32'hDEAD_BEEF);
      run_op("lh mis",0, 3'b001, 32'h0000_0001, 32'h0,        0, 32'h0,         1, 4'b0000, 32'h0,        32'hDEAD_BEEF);
      run_op("ld f3", 0, 3'b011, 32'h0000_0000, 32'h0,        0, 32'h0,         1, 4'b0000, 32'h0,        32'hDEAD_BEEF);
      run_op("st f3", 1, 3'b100, 32'h0000_0000, 32'h0,        0, 32'h0,         1, 4'b0000, 32'h0,        32'hDEAD_BEEF);

      // Stray ack while idle
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
      tick();
      bus.mem_ack = 1'b0;
      chk("idle ack busy",  32'(bus.lsu_busy), 32'd0);
      chk("idle ack rdata", bus.lsu_rdata, 32'hDEAD_BEEF);

      // Reset in the second REQ cycle of a lw, then a late ack
      bus.lsu_start = 1'b1; bus.lsu_we = 1'b0; bus.lsu_funct3 = 3'b010; bus.lsu_addr = 32'h0000_7000;
      tick();
      bus.lsu_start = 1'b0;
      chk("abort req1", 32'(bus.mem_req), 32'd1);
      tick();
      chk("abort req2", 32'(bus.mem_req), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort req off", 32'(bus.mem_req), 32'd0);
      chk("abort no done", 32'(bus.lsu_done), 32'd0);
      chk("abort busy",    32'(bus.lsu_busy), 32'd0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h4444_4444;
      tick();
      bus.mem_ack = 1'b0;
      chk("late ack done",  32'(bus.lsu_done), 32'd0);
      chk("late ack busy",  32'(bus.lsu_busy), 32'd0);
      chk("late ack rdata", bus.lsu_rdata, 32'd0);

      // No ack at all
      bus.lsu_start = 1'b1; bus.lsu_addr = 32'h0000_8000;
      tick();
      bus.lsu_start = 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt = 0;
      while (bus.mem_req && cnt < 40) begin
         cnt++;
         tick();
      end
      chk("timeout req cycles", 32'(cnt), 32'd16);
      chk("timeout done", 32'(bus.lsu_done), 32'd1);
      chk("timeout err",  32'(bus.lsu_err), 32'd1);
      tick();
      chk("timeout idle", 32'(bus.lsu_busy), 32'd0);
`else
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus.mem_req) cnt++;
         tick();
      end
      chk("wait req cycles", 32'(cnt), 32'd100);
      chk("wait still req",  32'(bus.mem_req), 32'd1);
      chk("wait busy",       32'(bus.lsu_busy), 32'd1);
      chk("wait no done",    32'(bus.lsu_done), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
